// File: rtl/csr_ctrl_pkg.sv
// Shared types and constants for the CSR sequencer: FSM encoding, SYSTEM opcode,
// funct3 codes and the counter CSR numbers.
package csr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_WB,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_RW  = 3'b001;
  localparam logic [2:0] F3_RS  = 3'b010;
  localparam logic [2:0] F3_RC  = 3'b011;
  localparam logic [2:0] F3_RWI = 3'b101;
  localparam logic [2:0] F3_RSI = 3'b110;
  localparam logic [2:0] F3_RCI = 3'b111;

  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_TIME     = 12'hC01;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_TIMEH    = 12'hC81;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;

  // csr_addr[11:10] value marking a read-only CSR
  localparam logic [1:0] CSR_RO_FIELD = 2'b11;

endpackage

// File: rtl/csr_ctrl_if.sv
// Bus bundle between csr_ctrl and its neighbours: decode-stage handshake,
// CSR unit strobes/data, register-file writeback and retire/illegal pulses.
interface csr_ctrl_if;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins;
  logic [31:0] rs1_data;
  logic [11:0] csr_addr;
  logic        csr_read;
  logic        csr_write;
  logic        csr_set;
  logic        csr_clr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ins_ret;
  logic        illegal;

  modport master (
    input  ins_valid, ins, rs1_data, csr_rdata, wb_ready,
    output ins_ready, csr_addr, csr_read, csr_write, csr_set, csr_clr,
           csr_wdata, wb_valid, wb_rd, wb_data, ins_ret, illegal
  );

  modport slave (
    output ins_valid, ins, rs1_data, csr_rdata, wb_ready,
    input  ins_ready, csr_addr, csr_read, csr_write, csr_set, csr_clr,
           csr_wdata, wb_valid, wb_rd, wb_data, ins_ret, illegal
  );
endinterface

// File: rtl/csr_ctrl_decode.sv
// Combinational decode of a SYSTEM CSR instruction into strobes and operands.
// Optional CSR_CTRL_RO_CHECK_EN flags modifying accesses to read-only CSRs as illegal.
import csr_pkg::*;

module csr_decode (
  input  logic [31:0] ins,
  input  logic [31:0] rs1_data,
  output logic        legal,
  output logic        write,
  output logic        set,
  output logic        clr,
  output logic        read,
  output logic [31:0] wdata,
  output logic [4:0]  rd,
  output logic [11:0] addr
);

  logic [2:0] f3;
  logic [4:0] uimm;

  assign f3   = ins[14:12];
  assign uimm = ins[19:15];
  assign rd   = ins[11:7];
  assign addr = ins[31:20];
  assign read = (ins[11:7] != 5'd0);

  always_comb begin
    write = 1'b0;
    set   = 1'b0;
    clr   = 1'b0;
    wdata = f3[2] ? {27'd0, uimm} : rs1_data;
    // set/clear with a zero rs1 field is a pure read
    case (f3)
      F3_RW,  F3_RWI: write = 1'b1;
      F3_RS,  F3_RSI: set   = (uimm != 5'd0);
      F3_RC,  F3_RCI: clr   = (uimm != 5'd0);
      default: ;
    endcase
    legal = (ins[6:0] == OPC_SYSTEM) && (f3[1:0] != 2'b00);
`ifdef CSR_CTRL_RO_CHECK_EN
    if ((ins[31:30] == CSR_RO_FIELD) && (write || set || clr))
      legal = 1'b0;
`endif
  end

endmodule

// File: rtl/csr_ctrl.sv
// CSR access sequencer: accepts one CSR instruction, strobes the CSR unit for one
// cycle, returns the old value to writeback and pulses ins_ret. See CSR_CTRL_RO_CHECK_EN in csr_decode.
import csr_pkg::*;

module csr_ctrl (
  input  logic       clk,
  input  logic       rst,
  csr_ctrl_if.master bus
);

  state_t state, state_nxt;

  logic        dec_legal, dec_write, dec_set, dec_clr, dec_read;
  logic [31:0] dec_wdata;
  logic [4:0]  dec_rd;
  logic [11:0] dec_addr;

  logic        write_p1, set_p1, clr_p1, read_p1;
  logic [31:0] wdata_p1;
  logic [4:0]  rd_p1;
  logic [11:0] addr_p1;
  logic [31:0] rdata_p2;
  logic        accept;

  csr_decode u_decode (
    .ins      (bus.ins),
    .rs1_data (bus.rs1_data),
    .legal    (dec_legal),
    .write    (dec_write),
    .set      (dec_set),
    .clr      (dec_clr),
    .read     (dec_read),
    .wdata    (dec_wdata),
    .rd       (dec_rd),
    .addr     (dec_addr)
  );

  assign accept = bus.ins_valid && bus.ins_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // stage p1: decoded instruction captured on accept
  always_ff @(posedge clk) begin
    if (accept) begin
      write_p1 <= dec_write;
      set_p1   <= dec_set;
      clr_p1   <= dec_clr;
      read_p1  <= dec_read;
      wdata_p1 <= dec_wdata;
      rd_p1    <= dec_rd;
      addr_p1  <= dec_addr;
    end
  end

  // stage p2: CSR unit read data, valid the cycle after the strobe
  always_ff @(posedge clk) begin
    if (state == ST_WAIT) rdata_p2 <= bus.csr_rdata;
  end

  // Data outputs are gated by state, so they read 0 outside their window and in reset.
  always_comb begin
    state_nxt     = state;
    bus.ins_ready = 1'b0;
    bus.csr_addr  = 12'd0;
    bus.csr_read  = 1'b0;
    bus.csr_write = 1'b0;
    bus.csr_set   = 1'b0;
    bus.csr_clr   = 1'b0;
    bus.csr_wdata = 32'd0;
    bus.wb_valid  = 1'b0;
    bus.wb_rd     = 5'd0;
    bus.wb_data   = 32'd0;
    bus.ins_ret   = 1'b0;
    bus.illegal   = 1'b0;
    case (state)
      ST_IDLE: begin
        bus.ins_ready = !rst;
        if (bus.ins_valid && !rst)
          state_nxt = dec_legal ? ST_ACCESS : ST_ERR;
      end
      ST_ACCESS: begin
        bus.csr_addr  = addr_p1;
        bus.csr_wdata = wdata_p1;
        bus.csr_read  = read_p1;
        bus.csr_write = write_p1;
        bus.csr_set   = set_p1;
        bus.csr_clr   = clr_p1;
        state_nxt     = read_p1 ? ST_WAIT : ST_DONE;
      end
      ST_WAIT: state_nxt = ST_WB;
      ST_WB: begin
        bus.wb_valid = 1'b1;
        bus.wb_rd    = rd_p1;
        bus.wb_data  = rdata_p2;
        if (bus.wb_ready) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        bus.ins_ret = 1'b1;
        state_nxt   = ST_IDLE;
      end
      ST_ERR: begin
        bus.illegal = 1'b1;
        state_nxt   = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
